// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the round-robin arbitrating multiplexer.
package rr_arb_mux_pkg;

  localparam int CHANNELS_MAX = 16;
  localparam int IDX_W        = 4;

  typedef enum logic [1:0] {
    OH_ZERO  = 2'd0,
    OH_ONE   = 2'd1,
    OH_MULTI = 2'd2
  } onehot_e;

  function automatic onehot_e onehot_check(input logic [CHANNELS_MAX-1:0] vec);
    int cnt;
    cnt = 0;
    for (int k = 0; k < CHANNELS_MAX; k++) begin
      if (vec[k]) begin
        cnt++;
      end
    end
    if (cnt == 0) begin
      return OH_ZERO;
    end else if (cnt == 1) begin
      return OH_ONE;
    end else begin
      return OH_MULTI;
    end
  endfunction

  // Only meaningful for a one-hot input; an all-zero vector maps to index 0.
  function automatic logic [IDX_W-1:0] onehot_to_index(input logic [CHANNELS_MAX-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = 4'd0;
    for (int k = 0; k < CHANNELS_MAX; k++) begin
      if (vec[k]) begin
        idx = idx | IDX_W'(k);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb_mux_grant.sv
// Combinational round-robin grant: first eligible channel at or above the
// pointer, wrapping, found by a double-width masked lowest-bit select.
module rr_grant #(
  parameter int CHANNELS = 4,
  parameter int PTR_W    = 2
) (
  input  logic [CHANNELS-1:0] eligible,
  input  logic [PTR_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant
);

  logic [CHANNELS-1:0]   one_s;
  logic [CHANNELS-1:0]   below_s;
  logic [2*CHANNELS-1:0] masked_s;
  logic [2*CHANNELS-1:0] first_s;

  // Upper copy covers the wrap; lower copy drops channels below the pointer.
  always_comb begin
    one_s    = {{(CHANNELS-1){1'b0}}, 1'b1};
    below_s  = (one_s << ptr) - one_s;
    masked_s = {eligible, eligible & ~below_s};
    first_s  = masked_s & (~masked_s + {{(2*CHANNELS-1){1'b0}}, 1'b1});
    grant    = first_s[CHANNELS-1:0] | first_s[2*CHANNELS-1:CHANNELS];
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel registered multiplexer with valid/ready handshakes, round-robin
// arbitration and a one-hot force override.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int BUS_WIDTH = 1,
  parameter int CHANNELS  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS*BUS_WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]           in_valid,
  output logic [CHANNELS-1:0]           in_ready,
  input  logic [CHANNELS-1:0]           force_sel,
  output logic [BUS_WIDTH-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS-1:0]           out_grant,
  output logic                          force_err
);

  localparam int PTR_W = $clog2(CHANNELS);

  logic [PTR_W-1:0]     ptr_r;
  logic [BUS_WIDTH-1:0] out_data_r;
  logic                 out_valid_r;
  logic [CHANNELS-1:0]  out_grant_r;
  logic                 force_err_r;

  onehot_e              force_kind_s;
  logic [CHANNELS-1:0]  eligible_s;
  logic [CHANNELS-1:0]  grant_s;
  logic                 slot_free_s;
  logic                 xfer_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic [PTR_W-1:0]     ptr_next_s;

  // Force qualification, handshake and next-pointer decode.
  always_comb begin
    force_kind_s = onehot_check(CHANNELS_MAX'(force_sel));
    if (force_kind_s == OH_ONE) begin
      eligible_s = force_sel & in_valid;
    end else begin
      eligible_s = in_valid;
    end
    slot_free_s = ~out_valid_r | out_ready;
    if (slot_free_s) begin
      in_ready = grant_s;
    end else begin
      in_ready = {CHANNELS{1'b0}};
    end
    // grant is a subset of in_valid, so any ready bit is a transfer
    xfer_s    = |in_ready;
    sel_idx_s = onehot_to_index(CHANNELS_MAX'(grant_s));
    if (int'(sel_idx_s) == CHANNELS - 1) begin
      ptr_next_s = {PTR_W{1'b0}};
    end else begin
      ptr_next_s = PTR_W'(int'(sel_idx_s) + 1);
    end
  end

  rr_grant #(
    .CHANNELS (CHANNELS),
    .PTR_W    (PTR_W)
  ) u_grant (
    .eligible (eligible_s),
    .ptr      (ptr_r),
    .grant    (grant_s)
  );

  // Output word, source tag, pointer and force error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r       <= {PTR_W{1'b0}};
      out_data_r  <= {BUS_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_grant_r <= {CHANNELS{1'b0}};
      force_err_r <= 1'b0;
    end else begin
      force_err_r <= (force_kind_s == OH_MULTI);
      if (xfer_s) begin
        out_data_r  <= in_data[int'(sel_idx_s)*BUS_WIDTH +: BUS_WIDTH];
        out_grant_r <= grant_s;
        out_valid_r <= 1'b1;
        ptr_r       <= ptr_next_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_grant = out_grant_r;
  assign force_err = force_err_r;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux (CHANNELS=4, BUS_WIDTH=8).
module tb_rr_arb_mux;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  force_sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_grant;
  logic        force_err;

  int n_cmp = 0;
  int n_err = 0;

  rr_arb_mux #(
    .BUS_WIDTH (8),
    .CHANNELS  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .force_sel (force_sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_grant (out_grant),
    .force_err (force_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [3:0] g, input logic [1:0] p);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_grant"}, 32'(out_grant), 32'(g));
    chk({tag, "_ptr"},   32'(dut.ptr_r), 32'(p));
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    in_valid  = 4'b0000;
    force_sel = 4'b0000;
    out_ready = 1'b0;

    // 1. reset then idle
    tick();
    tick();
    chk_out("reset", 1'b0, 8'h00, 4'b0000, 2'd0);
    chk("reset_ferr", 32'(force_err), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_grant", 32'(out_grant), 32'd0);
      chk("idle_ready", 32'(in_ready), 32'd0);
    end

    // 2. fairness
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_out("fair", 1'b1, 8'hA0 + 8'(k % 4), 4'b0001 << (k % 4), 2'((k + 1) % 4));
      chk("fair_ready", 32'(in_ready), 32'(4'b0001 << ((k + 1) % 4)));
    end

    // 3. backpressure on A1
    tick();
    chk_out("bp_a0", 1'b1, 8'hA0, 4'b0001, 2'd1);
    tick();
    chk_out("bp_a1", 1'b1, 8'hA1, 4'b0010, 2'd2);
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("bp_hold", 1'b1, 8'hA1, 4'b0010, 2'd2);
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk_out("bp_rel", 1'b1, 8'hA2, 4'b0100, 2'd3);

    // 4. wrap/skip from pointer 3
    in_valid = 4'b0101;
    tick();
    chk_out("wrap_ch0", 1'b1, 8'hA0, 4'b0001, 2'd1);
    tick();
    chk_out("wrap_ch2", 1'b1, 8'hA2, 4'b0100, 2'd3);

    // 5. force override, then invalid force
    in_valid  = 4'b1111;
    force_sel = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("force", 1'b1, 8'hA2, 4'b0100, 2'd3);
      chk("force_ferr", 32'(force_err), 32'd0);
    end
    force_sel = 4'b0110;
    tick();
    chk_out("ferr_rr3", 1'b1, 8'hA3, 4'b1000, 2'd0);
    chk("ferr_set", 32'(force_err), 32'd1);
    tick();
    chk_out("ferr_rr0", 1'b1, 8'hA0, 4'b0001, 2'd1);
    chk("ferr_hold", 32'(force_err), 32'd1);
    force_sel = 4'b0000;
    tick();
    chk_out("ferr_rr1", 1'b1, 8'hA1, 4'b0010, 2'd2);
    chk("ferr_clr", 32'(force_err), 32'd0);

    // 6. reset mid-stream
    out_ready = 1'b0;
    tick();
    chk_out("mid_stall", 1'b1, 8'hA1, 4'b0010, 2'd2);
    rst = 1'b1;
    tick();
    chk_out("mid_rst", 1'b0, 8'h00, 4'b0000, 2'd0);
    rst       = 1'b0;
    in_valid  = 4'b1000;
    out_ready = 1'b1;
    tick();
    chk_out("post_rst", 1'b1, 8'hA3, 4'b1000, 2'd0);
    in_valid = 4'b0000;
    tick();
    chk_out("drain", 1'b0, 8'hA3, 4'b1000, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
